// File: rtl/rob_packet_arbiter_pkg.sv
// Shared types and burst-length constants for the ROB packet arbiter.
// Imported by the arbiter top and its output register.
package rob_packet_arbiter_pkg;

  typedef enum logic {
    SRC_DECODER = 1'b0,
    SRC_RRU     = 1'b1
  } PacketSource_T;

  typedef enum logic [1:0] {
    IDLE,
    DEC_BURST,
    RRU_BURST
  } ArbState_T;

  localparam int DEC_TO_ROB_BEATS = 4;
  localparam int RRU_TO_ROB_BEATS = 2;

  function automatic int maxBeats(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rob_packet_arbiter_out_reg.sv
// Single-entry valid/ready register carrying one tagged packet word
// onto the ROB link; flush drops the held word.
module packet_out_reg #(
  parameter int DATA_W = 32,
  parameter int BEAT_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic [DATA_W-1:0] loadData,
  input  logic              loadSrc,
  input  logic [BEAT_W-1:0] loadBeat,
  input  logic              loadLast,
  input  logic              ready,
  output logic              canLoad,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              src,
  output logic [BEAT_W-1:0] beat,
  output logic              last
);

  assign canLoad = !valid || ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      src   <= 1'b0;
      beat  <= '0;
      last  <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= loadData;
      src   <= loadSrc;
      beat  <= loadBeat;
      last  <= loadLast;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rob_packet_arbiter.sv
// Round-robin burst arbiter sharing the ROB packet input between
// the instruction decoder and the register renaming unit.
module rob_packet_arbiter
  import rob_packet_arbiter_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEC_BEATS = DEC_TO_ROB_BEATS,
  parameter int RRU_BEATS = RRU_TO_ROB_BEATS,
  parameter int BEAT_W    = $clog2(maxBeats(DEC_BEATS, RRU_BEATS))
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              dec_valid,
  input  logic [DATA_W-1:0] dec_data,
  output logic              dec_ready,
  input  logic              rru_valid,
  input  logic [DATA_W-1:0] rru_data,
  output logic              rru_ready,
  output logic              rob_valid,
  output logic [DATA_W-1:0] rob_data,
  output logic              rob_src,
  output logic [BEAT_W-1:0] rob_beat,
  output logic              rob_last,
  input  logic              rob_ready
);

  localparam logic [BEAT_W-1:0] DEC_LAST = BEAT_W'(DEC_BEATS - 1);
  localparam logic [BEAT_W-1:0] RRU_LAST = BEAT_W'(RRU_BEATS - 1);

  ArbState_T         state;
  ArbState_T         stateNext;
  logic [BEAT_W-1:0] beatCnt;
  logic [BEAT_W-1:0] beatCntNext;
  PacketSource_T     rrPtr;
  PacketSource_T     rrPtrNext;

  logic              canLoad;
  logic              grantDec;
  logic              grantRru;
  logic              decFire;
  logic              rruFire;
  logic              fire;
  PacketSource_T     fireSrc;
  logic [BEAT_W-1:0] lastBeat;
  logic              isLast;
  logic [DATA_W-1:0] loadData;

  // In IDLE a tie goes to the source that did not own the last burst.
  always_comb begin
    grantDec = 1'b0;
    grantRru = 1'b0;
    unique case (state)
      IDLE: begin
        grantDec = dec_valid && (!rru_valid || rrPtr == SRC_RRU);
        grantRru = rru_valid && !grantDec;
      end
      DEC_BURST: grantDec = 1'b1;
      RRU_BURST: grantRru = 1'b1;
      default: begin
        grantDec = 1'b0;
        grantRru = 1'b0;
      end
    endcase
  end

  assign dec_ready = rst_n && !flush && grantDec && canLoad;
  assign rru_ready = rst_n && !flush && grantRru && canLoad;

  assign decFire  = dec_valid && dec_ready;
  assign rruFire  = rru_valid && rru_ready;
  assign fire     = decFire || rruFire;
  assign fireSrc  = rruFire ? SRC_RRU : SRC_DECODER;
  assign lastBeat = rruFire ? RRU_LAST : DEC_LAST;
  assign isLast   = (beatCnt == lastBeat);
  assign loadData = rruFire ? rru_data : dec_data;

  always_comb begin
    stateNext   = state;
    beatCntNext = beatCnt;
    rrPtrNext   = rrPtr;
    if (flush) begin
      stateNext   = IDLE;
      beatCntNext = '0;
    end else if (fire) begin
      if (isLast) begin
        stateNext   = IDLE;
        beatCntNext = '0;
        rrPtrNext   = fireSrc;
      end else begin
        stateNext   = rruFire ? RRU_BURST : DEC_BURST;
        beatCntNext = beatCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      beatCnt <= '0;
      rrPtr   <= SRC_RRU;
    end else begin
      state   <= stateNext;
      beatCnt <= beatCntNext;
      rrPtr   <= rrPtrNext;
    end
  end

  packet_out_reg #(
    .DATA_W(DATA_W),
    .BEAT_W(BEAT_W)
  ) uOutReg (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .load     (fire),
    .loadData (loadData),
    .loadSrc  (fireSrc == SRC_RRU),
    .loadBeat (beatCnt),
    .loadLast (isLast),
    .ready    (rob_ready),
    .canLoad  (canLoad),
    .valid    (rob_valid),
    .data     (rob_data),
    .src      (rob_src),
    .beat     (rob_beat),
    .last     (rob_last)
  );

endmodule

// File: tb/tb_rob_packet_arbiter.sv
// Scoreboard bench for rob_packet_arbiter: accepted source words are
// queued with their expected tags and matched against the ROB link.
module tb_rob_packet_arbiter;
  import rob_packet_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int BW = 2;
  localparam int DN = DEC_TO_ROB_BEATS;
  localparam int RN = RRU_TO_ROB_BEATS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          dec_valid = 1'b0;
  logic [DW-1:0] dec_data = '0;
  logic          dec_ready;
  logic          rru_valid = 1'b0;
  logic [DW-1:0] rru_data = '0;
  logic          rru_ready;
  logic          rob_valid;
  logic [DW-1:0] rob_data;
  logic          rob_src;
  logic [BW-1:0] rob_beat;
  logic          rob_last;
  logic          rob_ready = 1'b1;

  rob_packet_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .dec_valid (dec_valid),
    .dec_data  (dec_data),
    .dec_ready (dec_ready),
    .rru_valid (rru_valid),
    .rru_data  (rru_data),
    .rru_ready (rru_ready),
    .rob_valid (rob_valid),
    .rob_data  (rob_data),
    .rob_src   (rob_src),
    .rob_beat  (rob_beat),
    .rob_last  (rob_last),
    .rob_ready (rob_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          src;
    logic [BW-1:0] beat;
    logic          last;
    logic [DW-1:0] data;
  } Beat_T;

  Beat_T expQ[$];
  logic  srcLog[$];

  int errCnt = 0;
  int chkCnt = 0;
  int cyc = 0;
  int popCnt = 0;
  int fireCnt = 0;
  int firstCyc = 0;
  int lastCyc = 0;
  int rruRdySeen = 0;

  int decIdx = 0;
  int rruIdx = 0;
  int decLeft = 0;
  int rruLeft = 0;
  int decSeq = 0;
  int rruSeq = 0;

  logic decFire = 1'b0;
  logic rruFire = 1'b0;
  logic abortNow = 1'b1;
  logic prevFire = 1'b0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    Beat_T e;
    cyc++;
    decFire  = dec_valid && dec_ready;
    rruFire  = rru_valid && rru_ready;
    abortNow = flush || !rst_n;
    if (abortNow) check("abortReady", {dec_ready, rru_ready}, 2'b00);
    check("exclusive", decFire && rruFire, 1'b0);
    if (prevFire) check("latency", rob_valid, 1'b1);
    if (rru_ready) rruRdySeen++;
    if (rob_valid && rob_ready) begin
      check("queued", expQ.size() != 0, 1'b1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        popCnt++;
        check("word", {rob_src, rob_beat, rob_last, rob_data}, e);
      end
    end
    if (abortNow) begin
      expQ.delete();
    end else begin
      if (decFire) begin
        check("noInterleaveDec", rruIdx, 0);
        expQ.push_back('{src: 1'b0, beat: BW'(decIdx),
                         last: (decIdx == DN - 1), data: dec_data});
        if (decIdx == 0) srcLog.push_back(1'b0);
      end
      if (rruFire) begin
        check("noInterleaveRru", decIdx, 0);
        expQ.push_back('{src: 1'b1, beat: BW'(rruIdx),
                         last: (rruIdx == RN - 1), data: rru_data});
        if (rruIdx == 0) srcLog.push_back(1'b1);
      end
      if (decFire || rruFire) begin
        if (fireCnt == 0) firstCyc = cyc;
        lastCyc = cyc;
        fireCnt++;
      end
    end
    prevFire = (decFire || rruFire) && !abortNow;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (abortNow) begin
      decIdx = 0;
      rruIdx = 0;
    end else begin
      if (decFire) begin
        decSeq++;
        if (decIdx == DN - 1) begin
          decIdx = 0;
          decLeft--;
        end else decIdx++;
      end
      if (rruFire) begin
        rruSeq++;
        if (rruIdx == RN - 1) begin
          rruIdx = 0;
          rruLeft--;
        end else rruIdx++;
      end
    end
    dec_valid = decLeft > 0;
    dec_data  = 32'hD000_0000 + DW'(decSeq);
    rru_valid = rruLeft > 0;
    rru_data  = 32'hA000_0000 + DW'(rruSeq);
  endtask

  task automatic runDone(input string tag, input int maxCyc);
    int n = 0;
    while ((decLeft > 0 || rruLeft > 0 || expQ.size() > 0) && n < maxCyc) begin
      step();
      n++;
    end
    check(tag, DW'(expQ.size() + decLeft + rruLeft), '0);
    step();
  endtask

  task automatic resetPulse();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic clearStats();
    srcLog.delete();
    fireCnt = 0;
    rruRdySeen = 0;
  endtask

  initial begin
    int n;
    logic [DW-1:0] held;
    int pops;

    step();
    step();
    check("rstOut", {rob_valid, rob_data, rob_src, rob_beat, rob_last}, '0);
    rst_n = 1'b1;
    step();

    // decoder alone
    clearStats();
    decLeft = 1;
    runDone("t1Done", 40);
    check("t1RruReady", rruRdySeen, 0);
    check("t1Bursts", srcLog.size(), 1);
    check("t1Contig", lastCyc - firstCyc + 1, fireCnt);
    check("t1Fires", fireCnt, DN);

    // both sources continuously after reset
    resetPulse();
    clearStats();
    decLeft = 2;
    rruLeft = 2;
    runDone("t2Done", 80);
    check("t2Bursts", srcLog.size(), 4);
    for (int i = 0; i < 4 && i < srcLog.size(); i++)
      check("t2Order", srcLog[i], (i % 2 == 1));
    check("t2Contig", lastCyc - firstCyc + 1, fireCnt);
    check("t2Fires", fireCnt, 2 * DN + 2 * RN);

    // decoder arrives mid RRU burst
    clearStats();
    rruLeft = 1;
    n = 0;
    while (rruIdx != 1 && n < 20) begin step(); n++; end
    check("t3Reach", rruIdx, 1);
    decLeft = 1;
    dec_valid = 1'b1;
    runDone("t3Done", 40);
    check("t3Bursts", srcLog.size(), 2);
    if (srcLog.size() == 2) begin
      check("t3First", srcLog[0], 1'b1);
      check("t3Second", srcLog[1], 1'b0);
    end
    check("t3Contig", lastCyc - firstCyc + 1, fireCnt);

    // ROB stall while holding decoder beat 1
    pops = popCnt;
    decLeft = 1;
    n = 0;
    while (!(rob_valid && rob_beat == 2'd1) && n < 20) begin step(); n++; end
    check("t4Reach", {rob_valid, rob_beat}, 3'b101);
    rob_ready = 1'b0;
    held = rob_data;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4Hold", rob_data, held);
      check("t4DecReady", dec_ready, 1'b0);
    end
    rob_ready = 1'b1;
    runDone("t4Done", 40);
    check("t4Count", popCnt - pops, DN);

    // flush after decoder beat 2 accepted
    decLeft = 1;
    n = 0;
    while (decIdx != 3 && n < 20) begin step(); n++; end
    check("t5Reach", decIdx, 3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5Valid", rob_valid, 1'b0);
    runDone("t5Done", 40);

    // reset in the middle of an RRU burst
    rruLeft = 1;
    n = 0;
    while (rruIdx != 1 && n < 20) begin step(); n++; end
    check("t6Reach", rruIdx, 1);
    rst_n = 1'b0;
    decLeft = 1;
    dec_valid = 1'b1;
    step();
    rst_n = 1'b1;
    check("t6Out", {rob_valid, rob_data, rob_src, rob_beat, rob_last}, '0);
    clearStats();
    runDone("t6Done", 40);
    check("t6Bursts", srcLog.size(), 2);
    if (srcLog.size() == 2) begin
      check("t6First", srcLog[0], 1'b0);
      check("t6Second", srcLog[1], 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
